// File: rtl/calc1_req_scheduler.sv
// ---------------------------------------------------------------------------
// calc1_req_scheduler
//
// Shares a single calc1 request port between four requesters. Requesters are
// granted round-robin. The block then drives calc1's two-cycle request
// (cmd+op1, then cmd=0+op2), waits for the answer, and returns it to the
// requester that was granted. A watchdog turns a missing answer into a
// timeout response (code 3).
//
// Handshake semantics: a request on lane i is taken on the rising edge of
// c_clk where req_valid[i] && req_ready[i]. req_ready is combinational, is
// only ever high in IDLE, and is one-hot (or zero). Responses are a one-cycle
// rsp_valid[i] pulse with no backpressure; rsp_resp/rsp_data are meaningful
// only in that cycle and read as 0 otherwise.
//
// Ports
//   c_clk          clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   req_valid[4]   per-requester request valid
//   req_cmd[16]    4-bit command per requester, lane i at [4i +: 4]
//   req_op1[128]   32-bit first operand per requester, lane i at [32i +: 32]
//   req_op2[128]   32-bit second operand per requester, lane i at [32i +: 32]
//   req_ready[4]   one-cycle grant pulse to the winning requester
//   rsp_valid[4]   one-cycle response pulse to the granted requester
//   rsp_resp[2]    response code (1 ok, 2 error, 3 timeout), shared
//   rsp_data[32]   response data, shared
//   calc_cmd_out   command to calc1
//   calc_data_out  data to calc1
//   calc_resp_in   response code from calc1
//   calc_data_in   response data from calc1
// ---------------------------------------------------------------------------
module calc1_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         c_clk,
    input  logic         reset,
    input  logic [3:0]   req_valid,
    input  logic [15:0]  req_cmd,
    input  logic [127:0] req_op1,
    input  logic [127:0] req_op2,
    output logic [3:0]   req_ready,
    output logic [3:0]   rsp_valid,
    output logic [1:0]   rsp_resp,
    output logic [31:0]  rsp_data,
    output logic [3:0]   calc_cmd_out,
    output logic [31:0]  calc_data_out,
    input  logic [1:0]   calc_resp_in,
    input  logic [31:0]  calc_data_in
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [1:0]         rr_ptr;     // highest-priority requester for the next grant
    logic [1:0]         gnt_q;      // requester owning the transaction in flight
    logic [31:0]        op2_q;      // second operand, sent one cycle after op1
    logic [CNT_W-1:0]   wd_cnt;     // WAIT cycles spent without a response

    logic               gnt_found;
    logic [1:0]         gnt_idx;
    logic [1:0]         scan_idx;

    // Round-robin search: first valid lane starting at rr_ptr, wrapping mod 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    always_comb begin
        req_ready = 4'd0;
        if (state == ST_IDLE && gnt_found && !reset) begin
            req_ready = 4'd1 << gnt_idx;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= 2'd0;
            gnt_q         <= 2'd0;
            op2_q         <= 32'd0;
            wd_cnt        <= '0;
            rsp_valid     <= 4'd0;
            rsp_resp      <= 2'd0;
            rsp_data      <= 32'd0;
            calc_cmd_out  <= 4'd0;
            calc_data_out <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        gnt_q         <= gnt_idx;
                        calc_cmd_out  <= req_cmd[{gnt_idx, 2'b00} +: 4];
                        calc_data_out <= req_op1[{gnt_idx, 5'b00000} +: 32];
                        op2_q         <= req_op2[{gnt_idx, 5'b00000} +: 32];
                        state         <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    calc_cmd_out  <= 4'd0;
                    calc_data_out <= op2_q;
                    state         <= ST_DATA;
                end
                ST_DATA: begin
                    calc_data_out <= 32'd0;
                    wd_cnt        <= '0;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response in the final watchdog cycle still wins.
                    if (calc_resp_in != 2'd0) begin
                        rsp_valid <= 4'd1 << gnt_q;
                        rsp_resp  <= calc_resp_in;
                        rsp_data  <= calc_data_in;
                        state     <= ST_RESP;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid <= 4'd1 << gnt_q;
                        rsp_resp  <= 2'd3;
                        rsp_data  <= 32'd0;
                        state     <= ST_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 4'd0;
                    rsp_resp  <= 2'd0;
                    rsp_data  <= 32'd0;
                    rr_ptr    <= gnt_q + 2'd1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_calc1_req_scheduler
//
// Bench for calc1_req_scheduler. A behavioural calc1 responder answers each
// two-cycle request after a programmable delay (or never). Expected responses
// are queued when a grant is seen and compared when rsp_valid pulses; the
// calc-side request sequence is checked against a second queue.
// ---------------------------------------------------------------------------
module tb_calc1_req_scheduler;

    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic         c_clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [15:0]  req_cmd;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [1:0]   rsp_resp;
    logic [31:0]  rsp_data;
    logic [3:0]   calc_cmd_out;
    logic [31:0]  calc_data_out;
    logic [1:0]   calc_resp_in;
    logic [31:0]  calc_data_in;

    initial begin
        c_clk = 1'b0;
        forever #5 c_clk = ~c_clk;
    end

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    calc1_req_scheduler #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_resp      (rsp_resp),
        .rsp_data      (rsp_data),
        .calc_cmd_out  (calc_cmd_out),
        .calc_data_out (calc_data_out),
        .calc_resp_in  (calc_resp_in),
        .calc_data_in  (calc_data_in)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];       // {idx, resp, data}
    logic [67:0] exp_calc_q[$];  // {cmd, op1, op2}

    int rsp_cnt   = 0;
    int rsp_cyc   = 0;
    int grant_cyc = 0;
    int data_cyc  = 0;

    int calc_delay = 0;
    bit calc_mute  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // calc1 behaviour: add/sub with overflow/underflow -> 2, shifts, others invalid -> 2.
    function automatic logic [33:0] calc_fn(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1:    calc_fn = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            4'd2:    calc_fn = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    calc_fn = {2'd1, a << b[4:0]};
            4'd6:    calc_fn = {2'd1, a >> b[4:0]};
            default: calc_fn = {2'd2, 32'd0};
        endcase
    endfunction

    // ---------------- calc1 responder model ----------------
    bit          r_phase = 1'b0;
    bit          r_pend  = 1'b0;
    int          r_wait  = 0;
    logic [3:0]  r_cmd   = 4'd0;
    logic [31:0] r_op1   = 32'd0;
    logic [33:0] r_ro    = 34'd0;
    logic [67:0] r_exp   = 68'd0;

    always @(negedge c_clk) begin
        calc_resp_in = 2'd0;
        calc_data_in = 32'd0;
        if (reset) begin
            r_phase = 1'b0;
            r_pend  = 1'b0;
        end else begin
            if (r_pend) begin
                if (r_wait == 0) begin
                    calc_resp_in = r_ro[33:32];
                    calc_data_in = r_ro[31:0];
                    r_pend = 1'b0;
                end else begin
                    r_wait--;
                end
            end
            if (!r_phase) begin
                if (calc_cmd_out != 4'd0) begin
                    if (exp_calc_q.size() == 0) begin
                        check("calc_unexpected_cmd", 32'(calc_cmd_out), 32'd0);
                    end else begin
                        r_exp = exp_calc_q.pop_front();
                        check("calc_cmd", 32'(calc_cmd_out), 32'(r_exp[67:64]));
                        check("calc_op1", calc_data_out, r_exp[63:32]);
                    end
                    r_cmd   = calc_cmd_out;
                    r_op1   = calc_data_out;
                    r_phase = 1'b1;
                end
            end else begin
                check("calc_cmd_zero", 32'(calc_cmd_out), 32'd0);
                check("calc_op2", calc_data_out, r_exp[31:0]);
                r_ro     = calc_fn(r_cmd, r_op1, calc_data_out);
                r_pend   = !calc_mute;
                r_wait   = calc_delay;
                r_phase  = 1'b0;
                data_cyc = cyc;
            end
        end
    end

    // ---------------- response monitor ----------------
    logic [35:0] m_exp;

    always @(negedge c_clk) begin
        if (!reset) begin
            if (rsp_valid != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("rsp_valid_idx", 32'(rsp_valid), 32'(4'd1 << m_exp[35:34]));
                    check("rsp_resp", 32'(rsp_resp), 32'(m_exp[33:32]));
                    check("rsp_data", rsp_data, m_exp[31:0]);
                end
                rsp_cnt++;
                rsp_cyc = cyc;
            end else begin
                check("rsp_idle_zero", {rsp_data[31:2], rsp_data[1:0] | rsp_resp}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int idx, input logic [3:0] cmd, input logic [31:0] op1,
                            input logic [31:0] op2);
        req_cmd[idx*4 +: 4]   = cmd;
        req_op1[idx*32 +: 32] = op1;
        req_op2[idx*32 +: 32] = op2;
    endtask

    // Called just after a negedge; returns at the negedge following the grant edge.
    task automatic send(input int idx, input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [33:0] exp_ro);
        bit got;
        got = 1'b0;
        set_lane(idx, cmd, op1, op2);
        req_valid[idx] = 1'b1;
        for (int n = 0; n < 80 && !got; n++) begin
            #1;
            if (req_ready[idx]) begin
                got = 1'b1;
                grant_cyc = cyc;
                exp_q.push_back({2'(idx), exp_ro});
                exp_calc_q.push_back({cmd, op1, op2});
            end
            @(negedge c_clk);
        end
        req_valid[idx] = 1'b0;
        if (!got) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        for (int n = 0; n < 200 && rsp_cnt < target; n++) begin
            @(negedge c_clk);
            #2;
        end
        if (rsp_cnt < target) check("rsp_wait_timeout", 32'(rsp_cnt), 32'(target));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          idx;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int          delay;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[8];

    // ---------------- main sequence ----------------
    initial begin
        int base;
        bit got;

        vecs[0] = '{0, 4'd1, 32'h1,        32'h1FF_FFFF, 0,  2'd1, 32'h200_0000};
        vecs[1] = '{2, 4'd1, 32'hFFFF_FFFF, 32'h1,       1,  2'd2, 32'h0};
        vecs[2] = '{1, 4'd5, 32'h4,        32'h1,        0,  2'd1, 32'h8};
        vecs[3] = '{3, 4'd3, 32'h7,        32'h7,        2,  2'd2, 32'h0};
        vecs[4] = '{0, 4'd2, 32'hA,        32'h3,        3,  2'd1, 32'h7};
        vecs[5] = '{2, 4'd2, 32'h3,        32'hA,        0,  2'd2, 32'h0};
        // Answer lands in the last watchdog cycle: the real response must win.
        vecs[6] = '{1, 4'd6, 32'h80,       32'h3,        15, 2'd1, 32'h10};
        vecs[7] = '{3, 4'd1, 32'h7FFF_FFFF, 32'h1,       4,  2'd1, 32'h8000_0000};

        reset     = 1'b1;
        req_valid = 4'hF;
        req_cmd   = 16'd0;
        req_op1   = 128'd0;
        req_op2   = 128'd0;

        // Reset state: every output 0 even with all requests valid.
        repeat (3) @(negedge c_clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_calc_cmd", 32'(calc_cmd_out), 32'd0);
        check("reset_calc_data", calc_data_out, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        req_valid = 4'h0;
        reset     = 1'b0;
        @(negedge c_clk);

        // All four valid from reset: grants 0,1,2,3, each a single pulse.
        calc_delay = 2;
        base = rsp_cnt;
        for (int k = 0; k < 4; k++) set_lane(k, 4'd1, 32'(k * 16), 32'(k + 1));
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int n = 0; n < 60 && !got; n++) begin
                #1;
                if (req_ready != 4'd0) got = 1'b1;
                else @(negedge c_clk);
            end
            check("rr_order", 32'(req_ready), 32'(4'd1 << k));
            exp_q.push_back({2'(k), calc_fn(4'd1, 32'(k * 16), 32'(k + 1))});
            exp_calc_q.push_back({4'd1, 32'(k * 16), 32'(k + 1)});
            @(negedge c_clk);
            req_valid[k] = 1'b0;
            #1;
            check("ready_single_pulse", 32'(req_ready), 32'd0);
        end
        wait_rsp(base + 4);

        // Table of single transactions; latency is grant + 4 + responder delay.
        foreach (vecs[i]) begin
            calc_delay = vecs[i].delay;
            base = rsp_cnt;
            send(vecs[i].idx, vecs[i].cmd, vecs[i].op1, vecs[i].op2, {vecs[i].resp, vecs[i].data});
            wait_rsp(base + 1);
            check("latency", 32'(rsp_cyc - grant_cyc), 32'(4 + vecs[i].delay));
        end

        // Silent calc1: TIMEOUT silent WAIT cycles after DATA, then RESP with code 3.
        calc_mute = 1'b1;
        base = rsp_cnt;
        send(0, 4'd1, 32'h5, 32'h6, {2'd3, 32'd0});
        wait_rsp(base + 1);
        check("timeout_cycles", 32'(rsp_cyc - data_cyc), 32'(TIMEOUT + 1));
        calc_mute = 1'b0;
        calc_delay = 0;
        base = rsp_cnt;
        send(1, 4'd1, 32'h20, 32'h22, {2'd1, 32'h42});
        wait_rsp(base + 1);

        // Reset during WAIT with the RR pointer parked at 2.
        base = rsp_cnt;
        send(1, 4'd1, 32'h2, 32'h3, {2'd1, 32'h5});
        wait_rsp(base + 1);
        calc_mute = 1'b1;
        send(2, 4'd1, 32'h9, 32'h9, {2'd1, 32'h12});
        repeat (2) @(negedge c_clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_calc_q.delete();
        @(negedge c_clk);
        #2;
        check("midreset_calc_cmd", 32'(calc_cmd_out), 32'd0);
        check("midreset_calc_data", calc_data_out, 32'd0);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_rsp", {rsp_data[31:2], rsp_data[1:0] | rsp_resp}, 32'd0);
        check("midreset_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        calc_mute = 1'b0;
        base = rsp_cnt;
        repeat (20) @(negedge c_clk);
        #2;
        check("no_rsp_after_reset", 32'(rsp_cnt), 32'(base));

        // Lanes 1 and 3 valid: a reset pointer gives lane 1.
        set_lane(1, 4'd5, 32'h4, 32'h1);
        set_lane(3, 4'd3, 32'h1, 32'h1);
        req_valid = 4'b1010;
        #1;
        check("post_reset_grant", 32'(req_ready), 32'h2);
        if (req_ready == 4'b0010) begin
            exp_q.push_back({2'd1, 2'd1, 32'h8});
            exp_calc_q.push_back({4'd5, 32'h4, 32'h1});
        end
        @(negedge c_clk);
        req_valid = 4'b0000;
        wait_rsp(base + 1);
        send(3, 4'd3, 32'h1, 32'h1, {2'd2, 32'd0});
        wait_rsp(base + 2);

        repeat (3) @(negedge c_clk);
        check("queue_drained", 32'(exp_q.size() + exp_calc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
